// File: rtl/lj_pair_arbiter.sv
// lj_pair_arbiter: round-robin arbiter that feeds NUM_REQ pair-filter requesters
// into one shared LJ evaluator. It screens r2 against the table range, tracks
// tags through a shadow pipeline, and buffers tagged forces in a FWFT FIFO.
// Credits cover every issued-but-not-popped pair, so the FIFO never overflows.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_valid/req_ready           per-requester pair handshake (ready one-hot)
//   req_r2/req_d/req_ref_id/nb_id requester pair operands and particle IDs
//   eval_r2_valid/eval_r2/eval_d  issue to evaluator
//   eval_force/eval_force_valid   evaluator result
//   out_valid/out_ready/out_*     tagged force result toward accumulators
//   drop_cnt, tag_err, idle       status

package md_pkg;
   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned SEGMENT_NUM = 9;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] z;
      logic [DATA_WIDTH-1:0] y;
      logic [DATA_WIDTH-1:0] x;
   } data_tuple_t;
endpackage

module lj_pair_arbiter
   import md_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned LATENCY    = 14,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned EXP_OFFSET = 118
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_r2,
   input  data_tuple_t [NUM_REQ-1:0]            req_d,
   input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]     req_ref_id,
   input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]     req_nb_id,
   output logic                                 eval_r2_valid,
   output logic [DATA_WIDTH-1:0]                eval_r2,
   output data_tuple_t                          eval_d,
   input  data_tuple_t                          eval_force,
   input  logic                                 eval_force_valid,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output data_tuple_t                          out_force,
   output logic [$clog2(NUM_REQ)-1:0]           out_req_idx,
   output logic [ID_WIDTH-1:0]                  out_ref_id,
   output logic [ID_WIDTH-1:0]                  out_nb_id,
   output logic [15:0]                          drop_cnt,
   output logic                                 tag_err,
   output logic                                 idle
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned TAG_W   = IDX_W + 2 * ID_WIDTH;
   localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENT_W   = $bits(data_tuple_t) + TAG_W;

   logic [IDX_W-1:0]      r_rr_ptr;
   logic                  r_iss_vld;
   logic [DATA_WIDTH-1:0] r_eval_r2;
   data_tuple_t           r_eval_d;
   logic [TAG_W-1:0]      r_iss_tag;
   logic [LATENCY-1:0]    r_sh_vld;
   logic [TAG_W-1:0]      r_sh_tag [LATENCY];
   logic [CNT_W-1:0]      r_inflight;
   logic [CNT_W-1:0]      r_fifo_cnt;
   logic [FIFO_AW-1:0]    r_wr_ptr;
   logic [FIFO_AW-1:0]    r_rd_ptr;
   logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
   logic [15:0]           r_drop_cnt;
   logic                  r_tag_err;

   logic                  w_credit_ok;
   logic                  w_grant_vld;
   logic [IDX_W-1:0]      w_grant_idx;
   logic [IDX_W-1:0]      w_cand;
   logic [7:0]            w_exp_rel;
   logic                  w_in_range;
   logic                  w_issue;
   logic                  w_drop;
   logic                  w_tail_vld;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   // Credit covers the issue register, shadow pipeline and FIFO contents.
   assign w_credit_ok = ((CNT_W+1)'(r_inflight) + (CNT_W+1)'(r_fifo_cnt)) < (CNT_W+1)'(FIFO_DEPTH);

   // Round-robin search starting at r_rr_ptr; grants are suppressed in reset.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_cand = r_rr_ptr + IDX_W'(i);
         if (!w_grant_vld && req_valid[w_cand]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_cand;
         end
      end
      w_grant_vld = w_grant_vld & w_credit_ok & rst;
   end

   assign req_ready = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;

   // Exponent relative to segment 0, wrapping mod 256; sign bit ignored.
   assign w_exp_rel  = req_r2[w_grant_idx][30:23] - 8'(EXP_OFFSET);
   assign w_in_range = 32'(w_exp_rel) < SEGMENT_NUM;
   assign w_issue    = w_grant_vld & w_in_range;
   assign w_drop     = w_grant_vld & ~w_in_range;

   // Pointer, issue register and status counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rr_ptr   <= '0;
         r_iss_vld  <= 1'b0;
         r_eval_r2  <= '0;
         r_eval_d   <= '0;
         r_iss_tag  <= '0;
         r_drop_cnt <= '0;
         r_tag_err  <= 1'b0;
      end else begin
         if (w_grant_vld) r_rr_ptr <= w_grant_idx + IDX_W'(1);
         r_iss_vld <= w_issue;
         if (w_issue) begin
            r_eval_r2 <= req_r2[w_grant_idx];
            r_eval_d  <= req_d[w_grant_idx];
            r_iss_tag <= {w_grant_idx, req_ref_id[w_grant_idx], req_nb_id[w_grant_idx]};
         end
         if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_tail_vld ^ eval_force_valid) r_tag_err <= 1'b1;
      end
   end

   assign eval_r2_valid = r_iss_vld;
   assign eval_r2       = r_eval_r2;
   assign eval_d        = r_eval_d;
   assign drop_cnt      = r_drop_cnt;
   assign tag_err       = r_tag_err;

   // Shadow pipeline fed from the issue register so its tail lines up with
   // eval_force_valid LATENCY cycles after eval_r2_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh_vld <= '0;
         for (int unsigned k = 0; k < LATENCY; k++) r_sh_tag[k] <= '0;
      end else begin
         r_sh_vld    <= {r_sh_vld[LATENCY-2:0], r_iss_vld};
         r_sh_tag[0] <= r_iss_tag;
         for (int unsigned k = 1; k < LATENCY; k++) r_sh_tag[k] <= r_sh_tag[k-1];
      end
   end

   assign w_tail_vld = r_sh_vld[LATENCY-1];

   // FIFO control: a returning tail always releases its in-flight slot.
   assign w_empty = (r_fifo_cnt == '0);
   assign w_full  = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign w_pop   = ~w_empty & out_ready;
   assign w_push  = w_tail_vld & eval_force_valid & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_tail_vld);
         r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
         if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
   end

   // Storage array is not reset; the read side is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {eval_force, r_sh_tag[LATENCY-1]};
   end

   always_comb begin
      out_valid = ~w_empty;
      {out_force, out_req_idx, out_ref_id, out_nb_id} = w_empty ? ENT_W'(0) : r_mem[r_rd_ptr];
   end

   assign idle = (r_inflight == '0) & w_empty & ~r_iss_vld;

endmodule

// File: tb/tb_lj_pair_arbiter.sv
// Scoreboard bench for lj_pair_arbiter: randomized and directed requester
// traffic, an evaluator stub with fixed latency, and a reference model of
// round-robin, credit, range screening, drop saturation and tag errors.
module tb_lj_pair_arbiter;
   import md_pkg::*;

   localparam int NREQ  = 4;
   localparam int LAT   = 14;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   logic [NREQ-1:0]         req_valid, req_ready;
   logic [NREQ-1:0][31:0]   req_r2;
   data_tuple_t [NREQ-1:0]  req_d;
   logic [NREQ-1:0][7:0]    req_ref_id, req_nb_id;
   logic                    eval_r2_valid;
   logic [31:0]             eval_r2;
   data_tuple_t             eval_d, eval_force, out_force;
   logic                    eval_force_valid, out_valid, out_ready;
   logic [1:0]              out_req_idx;
   logic [7:0]              out_ref_id, out_nb_id;
   logic [15:0]             drop_cnt;
   logic                    tag_err, idle;

   lj_pair_arbiter #(.NUM_REQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_WIDTH(8), .EXP_OFFSET(118)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_r2(req_r2),
      .req_d(req_d), .req_ref_id(req_ref_id), .req_nb_id(req_nb_id),
      .eval_r2_valid(eval_r2_valid), .eval_r2(eval_r2), .eval_d(eval_d),
      .eval_force(eval_force), .eval_force_valid(eval_force_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_force(out_force),
      .out_req_idx(out_req_idx), .out_ref_id(out_ref_id), .out_nb_id(out_nb_id),
      .drop_cnt(drop_cnt), .tag_err(tag_err), .idle(idle));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] r2;
      data_tuple_t d;
      logic [7:0]  ref_id;
      logic [7:0]  nb_id;
   } pair_t;

   typedef struct {
      logic [1:0]  idx;
      logic [7:0]  ref_id;
      logic [7:0]  nb_id;
      data_tuple_t f;
      int          gc;
      bit          chk_lat;
   } exp_t;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   pair_t pbuf [NREQ][256];
   int ph [NREQ];
   int pt [NREQ];
   exp_t exp_q [$];

   // model state
   int          rr = 0;
   int          outstanding = 0;
   bit          model_ok = 0;
   bit          exp_eval_vld = 0;
   logic [31:0] exp_eval_r2 = '0;
   logic [15:0] exp_drop = '0;
   bit          exp_tag = 0;
   logic        line_v [LAT];
   data_tuple_t line_f [LAT];

   // test controls
   bit want_rst = 0, want_ready = 1, flood = 0, rnd_gate = 0, inject = 0, inj_now = 0, tail_drv = 0;
   bit lat_chk_on = 0;
   int dut_grants [NREQ];
   int dut_grant_total = 0;

   task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   function automatic data_tuple_t fmodel(input logic [31:0] r2, input data_tuple_t d);
      data_tuple_t f;
      f.x = d.x ^ r2;
      f.y = d.y + 32'h0001_2345;
      f.z = ~d.z ^ {r2[15:0], r2[31:16]};
      return f;
   endfunction

   // In range when the exponent lies within SEGMENT_NUM segments above 118, mod 256.
   function automatic bit in_rng(input logic [31:0] r2);
      int e;
      e = (int'(r2[30:23]) - 118 + 256) % 256;
      return e < 9;
   endfunction

   function automatic pair_t rnd_pair();
      pair_t p;
      p.r2     = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 135)), 23'($urandom)};
      p.d      = {$urandom, $urandom, $urandom};
      p.ref_id = 8'($urandom);
      p.nb_id  = 8'($urandom);
      return p;
   endfunction

   task automatic push_pair(input int i, input pair_t p);
      pbuf[i][pt[i] % 256] = p;
      pt[i]++;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (ph[i] != pt[i]) return 0;
      return 1;
   endfunction

   task automatic clear_pending();
      for (int i = 0; i < NREQ; i++) ph[i] = pt[i];
   endtask

   task automatic model_cycle();
      int g;
      pair_t p;
      bit nxt_vld;
      if (!rst) begin
         check(req_ready == '0, "ready_in_reset", 128'(req_ready), 128'(0));
         rr = 0; outstanding = 0; exp_q.delete();
         exp_eval_vld = 0; exp_drop = '0; exp_tag = 0;
         for (int k = 0; k < LAT; k++) begin line_v[k] = 1'b0; line_f[k] = '0; end
         model_ok = 1;
         return;
      end
      if (!model_ok) return;
      check(eval_r2_valid == exp_eval_vld, "eval_r2_valid", 128'(eval_r2_valid), 128'(exp_eval_vld));
      if (exp_eval_vld) check(eval_r2 == exp_eval_r2, "eval_r2", 128'(eval_r2), 128'(exp_eval_r2));
      check(drop_cnt == exp_drop, "drop_cnt", 128'(drop_cnt), 128'(exp_drop));
      check(tag_err == exp_tag, "tag_err", 128'(tag_err), 128'(exp_tag));
      check(idle == (outstanding == 0), "idle", 128'(idle), 128'(outstanding == 0));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin dut_grants[i]++; dut_grant_total++; end
      g = -1;
      if (outstanding < DEPTH)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      check(req_ready == ((g >= 0) ? 4'(1 << g) : 4'(0)), "grant", 128'(req_ready), 128'((g >= 0) ? (1 << g) : 0));
      nxt_vld = 0;
      if (g >= 0) begin
         rr = (g + 1) % NREQ;
         if (flood) p = '{r2: 32'h3F80_0000, d: '0, ref_id: 8'd1, nb_id: 8'd2};
         else begin p = pbuf[g][ph[g] % 256]; ph[g]++; end
         if (in_rng(p.r2)) begin
            exp_q.push_back('{idx: 2'(g), ref_id: p.ref_id, nb_id: p.nb_id, f: fmodel(p.r2, p.d), gc: cyc, chk_lat: lat_chk_on});
            outstanding++;
            nxt_vld = 1;
            exp_eval_r2 = p.r2;
         end else if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
      end
      exp_eval_vld = nxt_vld;
      if (inj_now && !tail_drv) exp_tag = 1;
      // evaluator stub: capture what the DUT issues this cycle
      for (int k = LAT - 1; k > 0; k--) begin line_v[k] = line_v[k-1]; line_f[k] = line_f[k-1]; end
      line_v[0] = eval_r2_valid;
      line_f[0] = fmodel(eval_r2, eval_d);
   endtask

   task automatic step();
      pair_t p;
      @(posedge clk); #1;
      cyc++;
      rst       = ~want_rst;
      out_ready = want_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (flood) begin
            req_valid[i] = 1'b1; req_r2[i] = 32'h3F80_0000; req_d[i] = '0;
            req_ref_id[i] = 8'd1; req_nb_id[i] = 8'd2;
         end else if (ph[i] != pt[i] && (!rnd_gate || $urandom_range(0, 3) != 0)) begin
            p = pbuf[i][ph[i] % 256];
            req_valid[i] = 1'b1; req_r2[i] = p.r2; req_d[i] = p.d;
            req_ref_id[i] = p.ref_id; req_nb_id[i] = p.nb_id;
         end else begin
            req_valid[i] = 1'b0; req_r2[i] = $urandom; req_d[i] = {$urandom, $urandom, $urandom};
            req_ref_id[i] = 8'($urandom); req_nb_id[i] = 8'($urandom);
         end
      end
      tail_drv = line_v[LAT-1];
      inj_now  = inject;
      inject   = 0;
      eval_force_valid = line_v[LAT-1] | inj_now;
      eval_force       = inj_now ? data_tuple_t'({$urandom, $urandom, $urandom}) : line_f[LAT-1];
      @(negedge clk); #1;
      model_cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!(all_empty() && exp_q.size() == 0 && outstanding == 0) && n < budget) begin
         step();
         n++;
      end
      check(n < budget, "drain_timeout", 128'(n), 128'(budget));
   endtask

   // Output monitor: pops the scoreboard on every accepted result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst && model_ok && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_output", 128'({out_req_idx, out_ref_id, out_nb_id}), 128'(0));
            end else begin
               e = exp_q.pop_front();
               outstanding--;
               check({out_req_idx, out_ref_id, out_nb_id} == {e.idx, e.ref_id, e.nb_id}, "out_tag",
                     128'({out_req_idx, out_ref_id, out_nb_id}), 128'({e.idx, e.ref_id, e.nb_id}));
               check(out_force == e.f, "out_force", 128'(out_force), 128'(e.f));
               if (e.chk_lat) check(cyc - e.gc == 16, "latency", 128'(cyc - e.gc), 128'(16));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      pair_t p;
      rst = 1'b0; req_valid = '0; req_r2 = '0; req_d = '0; req_ref_id = '0; req_nb_id = '0;
      eval_force = '0; eval_force_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin ph[i] = 0; pt[i] = 0; dut_grants[i] = 0; end
      for (int k = 0; k < LAT; k++) begin line_v[k] = 1'b0; line_f[k] = '0; end

      // reset
      want_rst = 1; step(); step();
      want_rst = 0; step();
      check(out_valid == 1'b0, "rst_out_valid", 128'(out_valid), 128'(0));
      check(idle == 1'b1, "rst_idle", 128'(idle), 128'(1));

      // single pair from requester 2
      lat_chk_on = 1;
      push_pair(2, '{r2: 32'h3F00_0000, d: {32'h11, 32'h22, 32'h33}, ref_id: 8'd5, nb_id: 8'd7});
      drain(60);
      lat_chk_on = 0;

      // out-of-range pair from requester 1
      push_pair(1, '{r2: 32'h3F80_0000, d: '0, ref_id: 8'd9, nb_id: 8'd3});
      drain(20); step();
      check(drop_cnt == 16'd1, "drop_one", 128'(drop_cnt), 128'(1));

      // fairness: all requesters valid for 8 cycles
      for (int i = 0; i < NREQ; i++) begin
         dut_grants[i] = 0;
         for (int k = 0; k < 3; k++) begin p = rnd_pair(); p.r2[30:23] = 8'd120; push_pair(i, p); end
      end
      for (int c = 0; c < 8; c++) step();
      for (int i = 0; i < NREQ; i++) check(dut_grants[i] == 2, "fair_grants", 128'(dut_grants[i]), 128'(2));
      drain(100);

      // backpressure
      want_ready = 0;
      dut_grant_total = 0;
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 6; k++) begin p = rnd_pair(); p.r2[30:23] = 8'd122; push_pair(i, p); end
      for (int c = 0; c < 40; c++) step();
      check(dut_grant_total == DEPTH, "bp_grants", 128'(dut_grant_total), 128'(DEPTH));
      check(out_valid == 1'b1, "bp_out_valid", 128'(out_valid), 128'(1));
      check(idle == 1'b0, "bp_idle", 128'(idle), 128'(0));
      want_ready = 1;
      drain(200);

      // randomized traffic with random gating and backpressure
      rnd_gate = 1;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (pt[i] - ph[i] < 4 && $urandom_range(0, 1) == 1) push_pair(i, rnd_pair());
         want_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      rnd_gate = 0; want_ready = 1;
      drain(400);

      // drop counter saturation
      flood = 1;
      for (int c = 0; c < 65540; c++) step();
      flood = 0;
      step();
      check(drop_cnt == 16'hFFFF, "drop_saturate", 128'(drop_cnt), 128'(16'hFFFF));
      drain(40);

      // tag error: force without a matching tail
      inject = 1;
      for (int c = 0; c < 6; c++) step();
      check(tag_err == 1'b1, "tag_err_sticky", 128'(tag_err), 128'(1));

      // reset with 10 pairs in flight
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < ((i < 2) ? 3 : 2); k++) begin p = rnd_pair(); p.r2[30:23] = 8'd125; push_pair(i, p); end
      for (int c = 0; c < 11; c++) step();
      check(outstanding == 10, "inflight_before_rst", 128'(outstanding), 128'(10));
      want_rst = 1; step(); clear_pending();
      want_rst = 0; step();
      check(out_valid == 1'b0, "midrst_out_valid", 128'(out_valid), 128'(0));
      check(idle == 1'b1, "midrst_idle", 128'(idle), 128'(1));
      check(drop_cnt == 16'd0, "midrst_drop", 128'(drop_cnt), 128'(0));
      check(tag_err == 1'b0, "midrst_tag_err", 128'(tag_err), 128'(0));

      // traffic after reset
      rnd_gate = 1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (pt[i] - ph[i] < 4 && $urandom_range(0, 1) == 1) push_pair(i, rnd_pair());
         want_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rnd_gate = 0; want_ready = 1;
      drain(400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
